risc16_store_buffer: RTL
========================

Name: risc16_store_buffer

Overview:
- Data-side front-end placed directly downstream of the risc16 core's data bus (d_addr/d_oe/d_dout/d_we/d_din).
- Absorbs core stores into a FIFO and drains them to backing data memory over a valid/ready write port, so memory write latency never reaches the non-stalling core.
- Loads are served combinationally from the memory read port, with per-byte forwarding from pending buffered stores.

Parameters:
DEPTH, 4, number of store entries; power of two, minimum 2.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
d_addr  in  16  core byte address; word select = d_addr[15:1]
d_oe  in  1  core load request (combinational, same cycle)
d_dout  in  16  core store data, lanes already positioned by core
d_we  in  2  store lane enables; d_we[0] -> bits[15:8] (even byte), d_we[1] -> bits[7:0] (odd byte); 2'b00 = no store
d_din  out  16  load data to core, combinational
mem_raddr  out  16  memory read address = {d_addr[15:1],1'b0}
mem_re  out  1  equals d_oe
mem_rdata  in  16  memory read data, combinational async read
mem_wvalid  out  1  head entry valid
mem_wready  in  1  memory accepts head write this cycle
mem_waddr  out  16  head word address, bit0 = 0
mem_wdata  out  16  head data
mem_wstrb  out  2  head lane enables, same mapping as d_we
buf_full  out  1  count == DEPTH
buf_empty  out  1  count == 0
overflow  out  1  sticky: a store was dropped

Behaviour:
- Storage: circular FIFO of DEPTH entries {waddr[15:1], data[15:0], strb[1:0]}. Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Reset (asynchronous): pointers = 0, count = 0, overflow = 0. Outputs: mem_wvalid = 0, buf_empty = 1, buf_full = 0, mem_waddr/mem_wdata/mem_wstrb = 0. Reset mid-drain discards all pending entries. No write is issued after rst asserts.
- Push: d_we != 0 at a rising edge writes entry at tail; tail++, count++.
- Pop: mem_wvalid & mem_wready at a rising edge; head++, count--.
- mem_wvalid = !buf_empty. Head fields are driven from registered entry storage and are stable while mem_wvalid=1 and mem_wready=0.
- Store latency: a store pushed into an empty buffer at edge N shows mem_wvalid=1 in cycle N+1. Earliest possible pop is edge N+1.
- Simultaneous push and pop: both occur, count unchanged. This is legal when full: the pop frees the slot in the same edge.
- Full without pop: the store is dropped, overflow sets and stays 1 until reset, and no pointer moves.
- Load forwarding (combinational), evaluated independently per byte lane:
  - d_din lane = data from the youngest valid entry with matching waddr[15:1] and that lane's strb set.
  - Otherwise d_din lane = mem_rdata lane.
  - The entry being popped this cycle still counts as valid for forwarding.
  - A store presented in the same cycle is not forwarded; the core never issues a load and a store in the same cycle.
- d_din is driven regardless of d_oe.
- Memory ordering: entries drain strictly in program order. Two entries may target the same word.

Optional Feature:
- STORE_MERGE_EN defined:
  - A push whose word address matches the youngest valid entry merges into that entry: per-lane overwrite of data, strb ORed. No new slot is used and count does not change.
  - A merge is allowed even when the buffer is full.
  - Merging is suppressed if the youngest entry is the head and is popped in the same edge; that store then takes the normal push path.
- STORE_MERGE_EN undefined: every store occupies a new entry.

Test Plan:
- Reset, no traffic -> buf_empty=1, mem_wvalid=0, overflow=0, d_din=mem_rdata.
- sw 0x1234 @0x0010 with mem_wready=0, then load @0x0010 with mem_rdata=0xFFFF -> d_din=0x1234, mem_wvalid=1, mem_waddr=0x0010, mem_wstrb=11. Raise mem_wready -> one pop, buf_empty next cycle.
- sb 0xAB00 @0x0020 (d_we=01), then load @0x0021 with mem_rdata=0x5566 -> d_din=0xAB66 (upper lane forwarded, lower lane from memory).
- Two stores to the same word, 0x1111 then 0x2222 @0x0030 -> load returns 0x2222. Without STORE_MERGE_EN: writes drain in order 0x1111 then 0x2222. With STORE_MERGE_EN: count=1 and a single write of 0x2222.
- mem_wready=0, DEPTH+1 stores to distinct words -> buf_full after DEPTH stores, overflow=1 after the extra one, and the dropped store never appears on mem_w*. At full, a store with mem_wready=1 in the same cycle is accepted with count still DEPTH and overflow unchanged.
- Assert rst mid-drain with 3 entries pending -> mem_wvalid=0 immediately (asynchronous), buf_empty=1, overflow=0, and no further writes after release.

Source files
------------

// File: rtl/risc16_store_buffer.sv
// Store buffer between the risc16 core data port and data memory: FIFO-drained writes, per-byte load forwarding.
// Optional STORE_MERGE_EN: a store to the youngest entry's word merges into that entry.
module risc16_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  input  logic [15:0] d_dout,
  input  logic [1:0]  d_we,
  output logic [15:0] d_din,
  output logic [15:0] mem_raddr,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [15:0] mem_waddr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wstrb,
  output logic        buf_full,
  output logic        buf_empty,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [AW-1:0] head_q, head_d, tail_q, tail_d, young;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [14:0]   addr_q [DEPTH];
  logic [15:0]   data_q [DEPTH];
  logic [1:0]    strb_q [DEPTH];

  logic pop, store, merge, push, drop;

  assign buf_empty  = (count_q == '0);
  assign buf_full   = (count_q == FULL_CNT);
  assign overflow   = ovf_q;
  assign mem_wvalid = !buf_empty;
  assign mem_re     = d_oe;
  assign mem_raddr  = d_addr & 16'hFFFE;

  // Head fields read zero whenever nothing is pending, including straight out of reset.
  assign mem_waddr = mem_wvalid ? {addr_q[head_q], 1'b0} : 16'h0000;
  assign mem_wdata = mem_wvalid ? data_q[head_q] : 16'h0000;
  assign mem_wstrb = mem_wvalid ? strb_q[head_q] : 2'b00;

  assign young = tail_q - AW'(1);
  assign pop   = mem_wvalid & mem_wready;
  assign store = |d_we;

`ifdef STORE_MERGE_EN
  // A lone head entry leaving this edge cannot absorb the store.
  assign merge = store && !buf_empty && (addr_q[young] == d_addr[15:1]) &&
                 !((count_q == ONE_CNT) && pop);
`else
  assign merge = 1'b0;
`endif

  assign push = store && !merge && (!buf_full || pop);
  assign drop = store && !merge && buf_full && !pop;

  always_comb begin
    head_d  = pop  ? head_q + AW'(1) : head_q;
    tail_d  = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + ONE_CNT;
    else if (pop && !push) count_d = count_q - ONE_CNT;
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= d_addr[15:1];
      data_q[tail_q] <= d_dout;
      strb_q[tail_q] <= d_we;
    end else if (merge) begin
      if (d_we[0]) data_q[young][15:8] <= d_dout[15:8];
      if (d_we[1]) data_q[young][7:0]  <= d_dout[7:0];
      strb_q[young] <= strb_q[young] | d_we;
    end
  end

  // Walk oldest to youngest so the youngest matching store wins each lane.
  always_comb begin : fwd
    logic [AW-1:0] idx;
    idx   = '0;
    d_din = mem_rdata;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if (((AW+1)'(i) < count_q) && (addr_q[idx] == d_addr[15:1])) begin
        if (strb_q[idx][0]) d_din[15:8] = data_q[idx][15:8];
        if (strb_q[idx][1]) d_din[7:0]  = data_q[idx][7:0];
      end
    end
  end

endmodule
